// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// mem_access_unit
//
// Memory front end for the multi-cycle datapath. Turns the per-step control
// levels (MemRd/MemWr/IorD/IRWr) from the microprogrammed control unit into a
// registered req/ready handshake to a variable-latency unified memory. Holds
// the Instruction Register and Memory Data Register and asserts Stall while an
// access is in flight.
//
// Optional build macro:
//   MEM_TIMEOUT_EN : abort an access after TIMEOUT_CYCLES WAIT cycles without
//                    mem_ready, setting the sticky bus_err flag.
//
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles tolerated before abort (1..255), only used
//                    when MEM_TIMEOUT_EN is defined.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   MemRd, MemWr, IorD, IRWr      control levels, held stable while Stall=1
//   PC, ALUOut, B                 instruction address, data address, store data
//   mem_req, mem_we               registered request / write enable
//   mem_addr, mem_wdata           registered address / write data
//   mem_rdata, mem_ready          read data / access complete from memory
//   IR, OP_Code, MDR              instruction reg, IR[31:26], memory data reg
//   Stall                         combinational hold to control unit and PC
//   bus_err                       sticky error flag
//------------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        IorD,
    input  logic        IRWr,
    input  logic [31:0] PC,
    input  logic [31:0] ALUOut,
    input  logic [31:0] B,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] IR,
    output logic [5:0]  OP_Code,
    output logic [31:0] MDR,
    output logic        Stall,
    output logic        bus_err
);

    localparam int DATA_W = 32;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_issue;
    logic                r_req;
    logic                r_we;
    logic                r_ird;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_bus_err;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]          r_cnt;
    logic                w_timeout;

    // Counter holds the number of ready-less WAIT cycles already elapsed, so
    // the abort fires in the TIMEOUT_CYCLES-th WAIT cycle. Ready has priority.
    assign w_timeout = (r_state == WAIT) && !mem_ready && (r_cnt == TO_LAST);
`endif

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- FSM next state and combinational Stall ----
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        Stall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (MemRd || MemWr) begin
                    Stall       = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_nxt = DONE;
                end
`endif
            end
            // One Stall-free cycle lets the control unit step past the
            // memory micro-op before any new request can be issued.
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---- Request, address and data registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_ird     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_ir      <= '0;
            r_mdr     <= '0;
            r_bus_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt     <= 8'd0;
`endif
        end else begin
            if (w_issue) begin
                r_req   <= 1'b1;
                r_addr  <= IorD ? ALUOut : PC;
                r_wdata <= B;
                // A conflicting MemRd+MemWr step is treated as a write, so
                // it must never load IR.
                r_we    <= MemWr;
                r_ird   <= IRWr & ~MemWr;
                if (MemRd && MemWr) begin
                    r_bus_err <= 1'b1;
                end
`ifdef MEM_TIMEOUT_EN
                r_cnt   <= 8'd0;
`endif
            end

            if (r_state == WAIT) begin
                if (mem_ready) begin
                    if (!r_we) begin
                        r_mdr <= mem_rdata;
                        if (r_ird) begin
                            r_ir <= mem_rdata;
                        end
                    end
                    r_req <= 1'b0;
                    r_we  <= 1'b0;
                end
`ifdef MEM_TIMEOUT_EN
                else if (w_timeout) begin
                    r_req     <= 1'b0;
                    r_we      <= 1'b0;
                    r_bus_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
`endif
            end
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign IR        = r_ir;
    assign OP_Code   = r_ir[31:26];
    assign MDR       = r_mdr;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRd = 1'b0, MemWr = 1'b0, IorD = 1'b0, IRWr = 1'b0;
    logic [31:0] PC = '0, ALUOut = '0, B = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] IR, MDR;
    logic [5:0]  OP_Code;
    logic        Stall, bus_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_ir  = '0;
    logic [31:0] exp_mdr = '0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRd(MemRd), .MemWr(MemWr), .IorD(IorD), .IRWr(IRWr),
        .PC(PC), .ALUOut(ALUOut), .B(B),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .IR(IR), .OP_Code(OP_Code), .MDR(MDR),
        .Stall(Stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs for the new cycle
    // are driven here and outputs are sampled a further #1 later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({mem_req, mem_we, bus_err, Stall} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0000", {mem_req, mem_we, bus_err, Stall});
        end
        total++;
        if ({mem_addr, mem_wdata, IR, MDR} !== 128'd0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, IR, MDR});
        end
        MemRd = 1'b1; #1;
        total++;
        if (Stall !== 1'b1) begin
            bad++; $display("FAIL reset_stall_comb got=%b exp=1", Stall);
        end
        MemRd = 1'b0; #1;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_fetch();
        PC = 32'h4; IorD = 1'b0; MemRd = 1'b1; IRWr = 1'b1; #1;
        total++;
        if ({Stall, mem_req} !== 2'b10) begin
            bad++; $display("FAIL fetch_c0 got=%b exp=10", {Stall, mem_req});
        end
        cyc();
        mem_ready = 1'b1; mem_rdata = 32'h8C220008; #1;
        total++;
        if ({Stall, mem_req, mem_we, mem_addr} !== {3'b110, 32'h4}) begin
            bad++; $display("FAIL fetch_c1 got=%h exp=%h", {Stall, mem_req, mem_we, mem_addr}, {3'b110, 32'h4});
        end
        cyc();
        mem_ready = 1'b0; mem_rdata = '0; #1;
        exp_ir = 32'h8C220008; exp_mdr = 32'h8C220008;
        total++;
        if ({Stall, mem_req} !== 2'b00) begin
            bad++; $display("FAIL fetch_c2_stall got=%b exp=00", {Stall, mem_req});
        end
        total++;
        if ({IR, OP_Code, MDR} !== {exp_ir, 6'h23, exp_mdr}) begin
            bad++; $display("FAIL fetch_regs got=%h/%h/%h exp=%h/23/%h", IR, OP_Code, MDR, exp_ir, exp_mdr);
        end
        cyc();
        MemRd = 1'b0; IRWr = 1'b0;
        cyc();
    endtask

    task automatic test_held_control();
        IorD = 1'b1; ALUOut = 32'h40; MemRd = 1'b1; #1;
        cyc();
        mem_ready = 1'b1; mem_rdata = 32'h0000_0ABC; #1;
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin
            bad++; $display("FAIL held_req1 got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 32'h40});
        end
        cyc();
        mem_ready = 1'b0; #1;
        exp_mdr = 32'h0000_0ABC;
        total++;
        if ({Stall, mem_req, MDR, IR} !== {2'b00, exp_mdr, exp_ir}) begin
            bad++; $display("FAIL held_done got=%h exp=%h", {Stall, mem_req, MDR, IR}, {2'b00, exp_mdr, exp_ir});
        end
        cyc(); #1;
        total++;
        if ({Stall, mem_req} !== 2'b10) begin
            bad++; $display("FAIL held_idle got=%b exp=10", {Stall, mem_req});
        end
        cyc(); #1;
        total++;
        if ({Stall, mem_req, mem_addr} !== {2'b11, 32'h40}) begin
            bad++; $display("FAIL held_req2 got=%h exp=%h", {Stall, mem_req, mem_addr}, {2'b11, 32'h40});
        end
        mem_ready = 1'b1; mem_rdata = 32'h55;
        cyc();
        mem_ready = 1'b0; MemRd = 1'b0; #1;
        exp_mdr = 32'h55;
        total++;
        if (MDR !== exp_mdr) begin
            bad++; $display("FAIL held_mdr2 got=%h exp=%h", MDR, exp_mdr);
        end
        cyc();
    endtask

    task automatic test_load_wait();
        IorD = 1'b1; ALUOut = 32'h10; MemRd = 1'b1; IRWr = 1'b0; #1;
        total++;
        if (Stall !== 1'b1) begin
            bad++; $display("FAIL load_c0 got=%b exp=1", Stall);
        end
        for (int i = 1; i <= 3; i++) begin
            cyc(); #1;
            total++;
            if ({Stall, mem_req, mem_we, mem_addr} !== {3'b110, 32'h10}) begin
                bad++; $display("FAIL load_wait%0d got=%h exp=%h", i, {Stall, mem_req, mem_we, mem_addr}, {3'b110, 32'h10});
            end
        end
        cyc();
        mem_ready = 1'b1; mem_rdata = 32'h12345678; #1;
        total++;
        if ({Stall, mem_req} !== 2'b11) begin
            bad++; $display("FAIL load_c4 got=%b exp=11", {Stall, mem_req});
        end
        cyc();
        mem_ready = 1'b0; #1;
        exp_mdr = 32'h12345678;
        total++;
        if ({Stall, MDR, IR} !== {1'b0, exp_mdr, exp_ir}) begin
            bad++; $display("FAIL load_done got=%h exp=%h", {Stall, MDR, IR}, {1'b0, exp_mdr, exp_ir});
        end
        cyc();
        MemRd = 1'b0;
        cyc();
    endtask

    task automatic test_store();
        MemWr = 1'b1; IorD = 1'b1; ALUOut = 32'h20; B = 32'hDEADBEEF; #1;
        total++;
        if (Stall !== 1'b1) begin
            bad++; $display("FAIL store_c0 got=%b exp=1", Stall);
        end
        cyc(); #1;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h20, 32'hDEADBEEF}) begin
            bad++; $display("FAIL store_req got=%h exp=%h", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h20, 32'hDEADBEEF});
        end
        cyc();
        mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF; #1;
        total++;
        if ({mem_req, mem_we} !== 2'b11) begin
            bad++; $display("FAIL store_hold got=%b exp=11", {mem_req, mem_we});
        end
        cyc();
        mem_ready = 1'b0; #1;
        total++;
        if ({Stall, mem_req, mem_we, bus_err, IR, MDR} !== {4'b0000, exp_ir, exp_mdr}) begin
            bad++; $display("FAIL store_done got=%h exp=%h", {Stall, mem_req, mem_we, bus_err, IR, MDR}, {4'b0000, exp_ir, exp_mdr});
        end
        cyc();
        MemWr = 1'b0;
        cyc();
    endtask

    task automatic test_no_ready();
        IorD = 1'b1; ALUOut = 32'h30; MemRd = 1'b1; #1;
`ifdef MEM_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            cyc(); #1;
            total++;
            if ({Stall, mem_req} !== 2'b11) begin
                bad++; $display("FAIL timeout_wait%0d got=%b exp=11", i, {Stall, mem_req});
            end
        end
        cyc(); #1;
        total++;
        if ({Stall, mem_req, bus_err, MDR} !== {3'b001, exp_mdr}) begin
            bad++; $display("FAIL timeout_abort got=%h exp=%h", {Stall, mem_req, bus_err, MDR}, {3'b001, exp_mdr});
        end
        cyc();
        MemRd = 1'b0;
        cyc();
`else
        for (int i = 1; i <= 20; i++) begin
            cyc(); #1;
            total++;
            if ({Stall, mem_req, bus_err} !== 3'b110) begin
                bad++; $display("FAIL noready_wait%0d got=%b exp=110", i, {Stall, mem_req, bus_err});
            end
        end
        mem_ready = 1'b1; mem_rdata = 32'h77;
        cyc();
        mem_ready = 1'b0; MemRd = 1'b0; #1;
        exp_mdr = 32'h77;
        total++;
        if (MDR !== exp_mdr) begin
            bad++; $display("FAIL noready_late got=%h exp=%h", MDR, exp_mdr);
        end
        cyc();
`endif
    endtask

    task automatic test_conflict();
        MemRd = 1'b1; MemWr = 1'b1; IRWr = 1'b1; IorD = 1'b1; ALUOut = 32'h50; B = 32'h11; #1;
        cyc(); #1;
        total++;
        if ({mem_req, mem_we, bus_err, mem_wdata} !== {3'b111, 32'h11}) begin
            bad++; $display("FAIL conflict_req got=%h exp=%h", {mem_req, mem_we, bus_err, mem_wdata}, {3'b111, 32'h11});
        end
        mem_ready = 1'b1; mem_rdata = 32'h99;
        cyc();
        mem_ready = 1'b0; MemRd = 1'b0; MemWr = 1'b0; IRWr = 1'b0; #1;
        total++;
        if ({IR, MDR, bus_err} !== {exp_ir, exp_mdr, 1'b1}) begin
            bad++; $display("FAIL conflict_regs got=%h exp=%h", {IR, MDR, bus_err}, {exp_ir, exp_mdr, 1'b1});
        end
        cyc();
    endtask

    task automatic test_reset_mid_wait();
        PC = 32'h100; IorD = 1'b0; MemRd = 1'b1; IRWr = 1'b1; #1;
        cyc();
        cyc(); #1;
        total++;
        if (mem_req !== 1'b1) begin
            bad++; $display("FAIL rstwait_pre got=%b exp=1", mem_req);
        end
        rst_n = 1'b0; #1;
        total++;
        if ({mem_req, bus_err, IR, MDR, mem_addr} !== {2'b00, 96'd0}) begin
            bad++; $display("FAIL rstwait_clear got=%h exp=0", {mem_req, bus_err, IR, MDR, mem_addr});
        end
        MemRd = 1'b0; IRWr = 1'b0;
        cyc();
        rst_n = 1'b1; #1;
        total++;
        if ({Stall, mem_req} !== 2'b00) begin
            bad++; $display("FAIL rstwait_idle got=%b exp=00", {Stall, mem_req});
        end
        cyc();
        MemRd = 1'b1; #1;
        total++;
        if ({Stall, mem_req} !== 2'b10) begin
            bad++; $display("FAIL rstwait_new_c0 got=%b exp=10", {Stall, mem_req});
        end
        cyc(); #1;
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin
            bad++; $display("FAIL rstwait_new_c1 got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 32'h100});
        end
        mem_ready = 1'b1; mem_rdata = 32'h0;
        cyc();
        mem_ready = 1'b0; MemRd = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_held_control();
        test_load_wait();
        test_store();
        test_no_ready();
        test_conflict();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
